// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, word constants and FSM state type for the
// test-traffic frame generator.
package xgmii_pkg;

    localparam int LEN_W = 14;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
    localparam logic [63:0] PREAMBLE_WORD = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_TERM,
        ST_IFG
    } xgen_state_t;

    // Eight consecutive incrementing payload bytes, lane 0 holding the base.
    function automatic logic [63:0] payload_word(input logic [7:0] base);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            w[8*j +: 8] = base + 8'(j);
        end
        return w;
    endfunction

endpackage

// File: rtl/xgmii_tx_term_word.sv
// Builds the terminate word: r trailing payload bytes, then FD, then idles.
module xgmii_tx_term_word
    import xgmii_pkg::*;
(
    input  logic [2:0]  r,
    input  logic [7:0]  base,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    always_comb begin
        txd = IDLE_WORD;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) < r) begin
                txd[8*k +: 8] = base + 8'(k);
            end else if (3'(k) == r) begin
                txd[8*k +: 8] = XGMII_TERM;
            end
        end
        txc = 8'hFF << r;
    end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII test-traffic frame generator (start/preamble, counting payload, terminate, IFG).
// Define XGEN_STATS_EN to build the tx_frames/tx_bytes statistics counters.
module xgmii_frame_gen
    import xgmii_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 9600
) (
    input  logic              usrclk,
    input  logic              reset_n,
    input  logic              link_ok,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [7:0]        ifg_len,
    input  logic [15:0]       frame_count,
    output logic [63:0]       xgmii_txd,
    output logic [7:0]        xgmii_txc,
    output logic              busy,
    output logic              done,
    output logic [31:0]       tx_frames,
    output logic [47:0]       tx_bytes
);

    xgen_state_t       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, len_clamped;
    logic [7:0]        ifg_q, ifg_d;
    logic [15:0]       count_q, count_d;
    logic              cont_q, cont_d;
    logic [10:0]       data_left_q, data_left_d;
    logic [5:0]        ifg_left_q, ifg_left_d, ifg_words;
    logic [7:0]        byte_q, byte_d;
    logic              stop_pend_q, stop_pend_d;
    logic [63:0]       txd_q, txd_d, term_txd;
    logic [7:0]        txc_q, txc_d, term_txc;
    logic              busy_q, done_q, done_d;
    logic              frame_end, more_frames, stop_now;

    always_comb begin
        len_clamped = frame_len;
        if (frame_len < LEN_W'(MIN_LEN)) begin
            len_clamped = LEN_W'(MIN_LEN);
        end else if (frame_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // ceil((ifg - (7 - r)) / 8) folds to (ifg + r) / 8, which is also 0 when ifg fits in the TERM word.
    assign ifg_words   = 6'((9'(ifg_q) + 9'(len_q[2:0])) >> 3);
    assign more_frames = cont_q || (count_q != 16'd0);
    assign stop_now    = stop || stop_pend_q;

    xgmii_tx_term_word u_term (
        .r    (len_q[2:0]),
        .base (byte_q),
        .txd  (term_txd),
        .txc  (term_txc)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ifg_d       = ifg_q;
        count_d     = count_q;
        cont_d      = cont_q;
        data_left_d = data_left_q;
        ifg_left_d  = ifg_left_q;
        byte_d      = byte_q;
        frame_end   = 1'b0;
        done_d      = 1'b0;
        txd_d       = IDLE_WORD;
        txc_d       = 8'hFF;

        case (state_q)
            ST_IDLE: begin
                if (start && link_ok) begin
                    len_d   = len_clamped;
                    ifg_d   = ifg_len;
                    count_d = frame_count;
                    cont_d  = (frame_count == 16'd0);
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (len_q[LEN_W-1:3] == 11'd0) begin
                    state_d = ST_TERM;
                end else begin
                    state_d     = ST_DATA;
                    data_left_d = len_q[LEN_W-1:3] - 11'd1;
                end
            end
            ST_DATA: begin
                if (data_left_q == 11'd0) begin
                    state_d = ST_TERM;
                end else begin
                    data_left_d = data_left_q - 11'd1;
                end
            end
            ST_TERM: begin
                if (ifg_words == 6'd0) begin
                    frame_end = 1'b1;
                end else begin
                    state_d    = ST_IFG;
                    ifg_left_d = ifg_words - 6'd1;
                end
            end
            ST_IFG: begin
                if (ifg_left_q == 6'd0) begin
                    frame_end = 1'b1;
                end else begin
                    ifg_left_d = ifg_left_q - 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            if (more_frames && !stop_now) begin
                state_d = ST_PREAMBLE;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        // Outputs are registered, so the word is chosen by the state being entered.
        case (state_d)
            ST_PREAMBLE: begin
                txd_d  = PREAMBLE_WORD;
                txc_d  = 8'h01;
                byte_d = 8'd0;
            end
            ST_DATA: begin
                txd_d  = payload_word(byte_q);
                txc_d  = 8'h00;
                byte_d = byte_q + 8'd8;
            end
            ST_TERM: begin
                txd_d = term_txd;
                txc_d = term_txc;
                if (!cont_q) begin
                    count_d = count_q - 16'd1;
                end
            end
            default: ;
        endcase

        stop_pend_d = (state_d != ST_IDLE) &&
                      (stop_pend_q || (stop && (state_q != ST_IDLE)));
    end

    always_ff @(posedge usrclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            ifg_q       <= '0;
            count_q     <= '0;
            cont_q      <= 1'b0;
            data_left_q <= '0;
            ifg_left_q  <= '0;
            byte_q      <= '0;
            stop_pend_q <= 1'b0;
            txd_q       <= IDLE_WORD;
            txc_q       <= 8'hFF;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ifg_q       <= ifg_d;
            count_q     <= count_d;
            cont_q      <= cont_d;
            data_left_q <= data_left_d;
            ifg_left_q  <= ifg_left_d;
            byte_q      <= byte_d;
            stop_pend_q <= stop_pend_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef XGEN_STATS_EN
    logic [31:0] frames_q;
    logic [47:0] bytes_q;
    logic        term_enter;

    assign term_enter = (state_d == ST_TERM);

    always_ff @(posedge usrclk or negedge reset_n) begin
        if (!reset_n) begin
            frames_q <= '0;
            bytes_q  <= '0;
        end else if (term_enter) begin
            frames_q <= frames_q + 32'd1;
            bytes_q  <= bytes_q + 48'(len_q);
        end
    end

    assign tx_frames = frames_q;
    assign tx_bytes  = bytes_q;
`else
    assign tx_frames = '0;
    assign tx_bytes  = '0;
`endif

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Self-checking bench for xgmii_frame_gen: a frame model fills a scoreboard queue
// that is popped and compared every cycle the DUT produces a word.
module tb_xgmii_frame_gen;

    logic        usrclk;
    logic        reset_n;
    logic        link_ok;
    logic        start;
    logic        stop;
    logic [13:0] frame_len;
    logic [7:0]  ifg_len;
    logic [15:0] frame_count;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy;
    logic        done;
    logic [31:0] tx_frames;
    logic [47:0] tx_bytes;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;

    xgmii_frame_gen dut (
        .usrclk      (usrclk),
        .reset_n     (reset_n),
        .link_ok     (link_ok),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .ifg_len     (ifg_len),
        .frame_count (frame_count),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .busy        (busy),
        .done        (done),
        .tx_frames   (tx_frames),
        .tx_bytes    (tx_bytes)
    );

    initial usrclk = 1'b0;
    always #5 usrclk = ~usrclk;

    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        busy;
        logic        done;
        logic        is_term;
    } sb_t;

    typedef struct {
        int          flen;
        int          ifg;
        int          cnt;
        int          exp_busy;
        logic [63:0] exp_term_txd;
        logic [7:0]  exp_term_txc;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[6];
    int          vectors = 0;
    int          miscompares = 0;
    int          busy_seen;
    logic [63:0] last_term_txd;
    logic [7:0]  last_term_txc;
    logic [31:0] exp_frames = 0;
    logic [47:0] exp_bytes = 0;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushWord(input logic [63:0] d, input logic [7:0] c, input logic b,
                            input logic dn, input logic t);
        sb_t e;
        e.txd = d; e.txc = c; e.busy = b; e.done = dn; e.is_term = t;
        sb.push_back(e);
    endtask

    // Reference frame model written from the frame format, independent of the RTL.
    task automatic pushFrames(input int flen, input int ifg, input int cnt);
        int          l, r, nw, rem, nidle;
        logic [63:0] w;
        l     = (flen < 64) ? 64 : ((flen > 9600) ? 9600 : flen);
        r     = l % 8;
        nw    = l / 8;
        rem   = ifg - (7 - r);
        nidle = (rem <= 0) ? 0 : (rem + 7) / 8;
        for (int f = 0; f < cnt; f++) begin
            pushWord(PRE_W, 8'h01, 1'b1, 1'b0, 1'b0);
            for (int wi = 0; wi < nw; wi++) begin
                for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'((8*wi + j) % 256);
                pushWord(w, 8'h00, 1'b1, 1'b0, 1'b0);
            end
            for (int j = 0; j < 8; j++) begin
                if (j < r)       w[8*j +: 8] = 8'((8*nw + j) % 256);
                else if (j == r) w[8*j +: 8] = 8'hFD;
                else             w[8*j +: 8] = 8'h07;
            end
            pushWord(w, 8'(8'hFF << r), 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < nidle; i++) pushWord(IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        pushWord(IDLE_W, 8'hFF, 1'b0, 1'b1, 1'b0);
`ifdef XGEN_STATS_EN
        exp_frames += 32'(cnt);
        exp_bytes  += 48'(l * cnt);
`endif
    endtask

    // Called on a falling edge; start is sampled at the next rising edge.
    task automatic applyStimulus(input int flen, input int ifg, input int cnt);
        frame_len   = 14'(flen);
        ifg_len     = 8'(ifg);
        frame_count = 16'(cnt);
        start       = 1'b1;
        @(negedge usrclk);
        start       = 1'b0;
    endtask

    task automatic checkOutput();
        sb_t e;
        e = sb.pop_front();
        compare("txd", xgmii_txd, e.txd);
        compare("txc", 64'(xgmii_txc), 64'(e.txc));
        compare("busy", 64'(busy), 64'(e.busy));
        compare("done", 64'(done), 64'(e.done));
        if (busy) busy_seen++;
        if (e.is_term) begin
            last_term_txd = xgmii_txd;
            last_term_txc = xgmii_txc;
        end
    endtask

    task automatic drainQueue(input int stop_at);
        int k;
        k = 0;
        busy_seen = 0;
        while (sb.size() > 0) begin
            if (k == stop_at) stop = 1'b1;
            checkOutput();
            k++;
            @(negedge usrclk);
        end
        stop = 1'b0;
    endtask

    task automatic checkStats(input string tag);
        compare({tag, " tx_frames"}, 64'(tx_frames), 64'(exp_frames));
        compare({tag, " tx_bytes"}, 64'(tx_bytes), 64'(exp_bytes));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        vecs[0] = '{64,    12, 1, 11,   64'h07070707070707FD, 8'hFF};
        vecs[1] = '{67,    12, 1, 11,   64'h07070707FD424140, 8'hF8};
        vecs[2] = '{10,    12, 1, 11,   64'h07070707070707FD, 8'hFF};
        vecs[3] = '{16000, 12, 1, 1203, 64'h07070707070707FD, 8'hFF};
        vecs[4] = '{64,    0,  3, 30,   64'h07070707070707FD, 8'hFF};
        vecs[5] = '{100,   30, 2, 36,   64'h070707FD63626160, 8'hF0};

        reset_n = 1'b0; link_ok = 1'b1; start = 1'b0; stop = 1'b0;
        frame_len = '0; ifg_len = '0; frame_count = '0;
        repeat (3) @(negedge usrclk);
        compare("reset txd", xgmii_txd, IDLE_W);
        compare("reset txc", 64'(xgmii_txc), 64'hFF);
        compare("reset busy", 64'(busy), 64'd0);
        compare("reset done", 64'(done), 64'd0);
        checkStats("reset");
        reset_n = 1'b1;
        @(negedge usrclk);

        for (int v = 0; v < 6; v++) begin
            pushFrames(vecs[v].flen, vecs[v].ifg, vecs[v].cnt);
            applyStimulus(vecs[v].flen, vecs[v].ifg, vecs[v].cnt);
            drainQueue(-1);
            compare($sformatf("vec%0d busy cycles", v), 64'(busy_seen), 64'(vecs[v].exp_busy));
            compare($sformatf("vec%0d term txd", v), last_term_txd, vecs[v].exp_term_txd);
            compare($sformatf("vec%0d term txc", v), 64'(last_term_txc), 64'(vecs[v].exp_term_txc));
            checkStats($sformatf("vec%0d", v));
        end

        $display("[TB] continuous mode with stop in second frame");
        pushFrames(64, 12, 2);
        applyStimulus(64, 12, 0);
        drainQueue(14);
        compare("continuous busy cycles", 64'(busy_seen), 64'd22);
        checkStats("continuous");

        $display("[TB] start with link down");
        link_ok = 1'b0;
        for (int i = 0; i < 5; i++) pushWord(IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(64, 12, 1);
        drainQueue(-1);
        link_ok = 1'b1;

        $display("[TB] new start and link drop while busy");
        pushFrames(64, 12, 1);
        applyStimulus(64, 12, 1);
        k = 0;
        while (sb.size() > 0) begin
            if (k == 3) begin
                start = 1'b1; frame_len = 14'd200; ifg_len = 8'd40; link_ok = 1'b0;
            end
            if (k == 4) begin
                start = 1'b0; link_ok = 1'b1;
            end
            checkOutput();
            k++;
            @(negedge usrclk);
        end
        checkStats("busy ignore");

        $display("[TB] reset during DATA");
        applyStimulus(64, 12, 1);
        repeat (3) @(negedge usrclk);
        reset_n = 1'b0;
        #1;
        compare("async reset txd", xgmii_txd, IDLE_W);
        compare("async reset txc", 64'(xgmii_txc), 64'hFF);
        compare("async reset busy", 64'(busy), 64'd0);
        @(negedge usrclk);
        reset_n = 1'b1;
        exp_frames = 0;
        exp_bytes  = 0;
        @(negedge usrclk);
        compare("post reset txd", xgmii_txd, IDLE_W);
        compare("post reset done", 64'(done), 64'd0);
        checkStats("post reset");
        pushFrames(67, 12, 1);
        applyStimulus(67, 12, 1);
        drainQueue(-1);
        compare("post reset term txd", last_term_txd, 64'h07070707FD424140);
        checkStats("post reset frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xgmii_frame_gen.md
# xgmii_frame_gen

Test-traffic transmitter on the XGMII side of the XAUI core. It drives the 64-bit `xgmii_txd`/`xgmii_txc` bus that the core serialises to the MGTs. It builds complete frames: start word, preamble and SFD, an incrementing-byte payload, a terminate word, and inter-frame idles. Frame length, gap and count are software-programmed, and it runs in the `usrclk` domain of the core.

## Interface
- `MIN_LEN`, 64: minimum payload bytes after SFD; shorter requests are clamped up.
- `MAX_LEN`, 9600: maximum payload bytes; longer requests are clamped down (≤ 16383).
- `usrclk` in 1: core clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `link_ok` in 1: XAUI `align_status`; start is accepted only when this is high.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `stop` in 1: level; finish the current frame and its IFG, then return to IDLE.
- `frame_len` in 14: payload byte count; latched at start.
- `ifg_len` in 8: minimum idle bytes after the terminate character; latched at start.
- `frame_count` in 16: frames to send; 0 means continuous until `stop`; latched at start.
- `xgmii_txd` out 64: lane k is bits 8k+7:8k; lane 0 is transmitted first.
- `xgmii_txc` out 8: control flag per lane.
- `busy` out 1: high from the start word through the last IFG word.
- `done` out 1: one-cycle pulse on return to IDLE.
- `tx_frames` out 32: frames sent (see Configuration).
- `tx_bytes` out 48: payload bytes sent (see Configuration).

## Operation
- Constants: IDLE 0x07, START 0xFB, TERM 0xFD, PRE 0x55, SFD 0xD5.
- Idle word: `txd` = 0x0707070707070707, `txc` = 0xFF.
- States: IDLE, PREAMBLE, DATA, TERM, IFG.
- IDLE:
  - Outputs the idle word.
  - `start` && `link_ok` latches `L` = clamp(`frame_len`), the IFG length and the frame count, then goes to PREAMBLE.
  - `start` with `link_ok` low is ignored.
- PREAMBLE (1 word):
  - Lane 0 = FB; lanes 1–6 = 55; lane 7 = D5; `txc` = 0x01.
  - Goes to DATA, or to TERM if L/8 = 0. L/8 = 0 is unreachable with MIN_LEN ≥ 8.
- DATA: emits floor(L/8) words with `txc` = 0x00. Payload byte i (0-based from the SFD) = i mod 256, so lane j of data word w = (8w+j) mod 256.
- TERM (1 word), with r = L mod 8:
  - Lanes 0..r−1 carry the last r payload bytes (`txc` bits 0).
  - Lane r = FD; lanes r+1..7 = 07; those `txc` bits are 1.
  - `txc` = 0xFF << r (8-bit).
- IFG:
  - The terminate word holds 7−r idle bytes.
  - The block then emits `ceil(max(0, ifg_len − (7−r))/8)` full idle words.
  - After the last IFG word, or directly from TERM when that count is 0:
    - If frames remain and `stop` is low, go to PREAMBLE with no extra gap.
    - Otherwise go to IDLE and pulse `done`.
- Frame counter: decrements at each TERM when `frame_count` is nonzero; the last frame is the one where it reaches 0.
- `stop` asserted in any non-IDLE state: the current frame and its IFG complete, then the block enters IDLE.
- `link_ok` dropping mid-frame: no effect on the frame in progress; it gates only the next `start`.
- New `start`, `frame_len` or `ifg_len` values while `busy` is high are ignored.

## Timing
- All outputs are registered.
- The start word appears in the cycle after the edge that samples `start`.
- Frame duration = 1 + floor(L/8) + 1 + IFG words cycles.
- `busy` is high for exactly those cycles. `done` is high in the first IDLE cycle, when `busy` is already low.
- Reset values:
  - `xgmii_txd` = 0x0707070707070707, `xgmii_txc` = 0xFF.
  - `busy`, `done` = 0; `tx_frames`, `tx_bytes` = 0; state = IDLE.
- Reset asserted mid-frame: outputs take the idle word asynchronously. No terminate character is emitted, so the truncated frame is the receiver's concern.

## Configuration
- `XGEN_STATS_EN` defined:
  - `tx_frames` increments by 1 at each TERM word.
  - `tx_bytes` increments by L at each TERM word.
  - Both wrap modulo 2^32 and 2^48, and clear only on reset.
- `XGEN_STATS_EN` undefined: both ports remain and are tied to 0. No counter logic is built.

## Structure
- Package `xgmii_pkg`: the five XGMII character constants, the idle-word constant, the state enum type, and the length width (14).
- Sub-module `xgmii_tx_term_word`: combinational. Given r and the payload byte base, it returns the TERM `txd`/`txc`. It is instantiated once.
- Top level holds the FSM, length/IFG/frame counters, payload byte counter, and statistics.

## Test plan
- L=64, ifg=12, count=1 → start word FB,55×6,D5/`txc` 0x01; 8 data words with bytes 0x00–0x3F; TERM FD at lane 0 with `txc` 0xFF; 1 idle word; `done` pulse; 11 cycles of `busy`.
- L=67, ifg=12 → TERM word lanes 0–2 = 40,41,42, lane 3 FD, lanes 4–7 07, `txc` 0xF8; then 1 idle word.
- `frame_len`=10 → clamped to 64 (identical to the first case). `frame_len`=16000 → clamped to 9600, giving 1200 data words and TERM at lane 0.
- count=3, L=64, ifg=0 → three frames back to back: each frame's start word directly follows the previous TERM word. `done` occurs after the third frame. With stats enabled: `tx_frames`=3, `tx_bytes`=192.
- count=0 continuous, `stop` raised during the second frame's DATA → the second frame and its IFG complete, then IDLE. `start` with `link_ok`=0 → idle word persists and `busy` stays 0.
- `reset_n` low during DATA → the idle word appears in the same cycle with no FD emitted. After release, state = IDLE and counters = 0. A following `start` produces a correct frame.
